// File: rtl/data_memory_pkg.sv
// Shared defaults for the data memory: word width, depth and derived address width.
package data_memory_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefDepth     = 64;
    localparam int unsigned DefAddrWidth = $clog2(DefDepth);

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: combinational read, synchronous write, async clear on reset.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned DEPTH      = DefDepth
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Mem_read,
    input  logic                  Mem_write,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] Read_data
);

    localparam int unsigned AddrWidth = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  in_range;
    logic [AddrWidth-1:0]  idx;

    // Full 32-bit compare so aliased upper-bit addresses never hit storage.
    assign in_range = (addr < 32'(DEPTH));
    assign idx      = addr[AddrWidth-1:0];

    // Register array rather than RAM: reset must clear every word at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (Mem_write && in_range) begin
            mem[idx] <= write_data;
        end
    end

    always_comb begin
        Read_data = '0;
        if (reset && Mem_read && in_range) begin
            Read_data = mem[idx];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory with hand-computed expectations.
module tb_data_memory;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 64;

    logic          clk;
    logic          reset;
    logic          Mem_read;
    logic          Mem_write;
    logic [31:0]   addr;
    logic [DW-1:0] write_data;
    logic [DW-1:0] Read_data;

    int checks;
    int errors;

    data_memory #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Mem_read   (Mem_read),
        .Mem_write  (Mem_write),
        .addr       (addr),
        .write_data (write_data),
        .Read_data  (Read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic write_word(input logic [31:0] a, input logic [DW-1:0] d);
        Mem_write  = 1'b1;
        addr       = a;
        write_data = d;
        @(posedge clk);
        #1;
        Mem_write  = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [DW-1:0] exp);
        Mem_read = 1'b1;
        addr     = a;
        #1;
        check(tag, Read_data, exp);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        Mem_read   = 1'b1;
        Mem_write  = 1'b0;
        addr       = 32'd0;
        write_data = '0;

        repeat (2) @(posedge clk);
        #1;
        check("read_in_reset", Read_data, 32'h0);

        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            addr = 32'(i);
            #1;
            check($sformatf("reset_clear[%0d]", i), Read_data, 32'h0);
        end

        write_word(32'd2, 32'h0000_000C);
        read_check("wr2_rd2", 32'd2, 32'h0000_000C);
        read_check("wr2_rd3", 32'd3, 32'h0);
        read_check("wr2_rd1", 32'd1, 32'h0);

        Mem_read = 1'b0;
        addr     = 32'd2;
        #1;
        check("rd_disabled", Read_data, 32'h0);
        Mem_read = 1'b1;
        #1;
        check("rd_enabled", Read_data, 32'h0000_000C);

        write_word(32'd64, 32'hDEAD_BEEF);
        read_check("oob_rd64", 32'd64, 32'h0);
        read_check("oob_rd0", 32'd0, 32'h0);
        write_word(32'h4000_0002, 32'hDEAD_BEEF);
        read_check("alias_keeps2", 32'd2, 32'h0000_000C);
        read_check("alias_rd", 32'h4000_0002, 32'h0);
        read_check("last_word", 32'd63, 32'h0);

        write_word(32'd7, 32'h1);
        Mem_read   = 1'b1;
        Mem_write  = 1'b1;
        addr       = 32'd7;
        write_data = 32'h2;
        #1;
        check("rw_before_edge", Read_data, 32'h1);
        @(posedge clk);
        #1;
        check("rw_after_edge", Read_data, 32'h2);
        Mem_write = 1'b0;

        write_data = 32'h9;
        @(posedge clk);
        #1;
        check("no_write_en", Read_data, 32'h2);

        write_word(32'd63, 32'hCAFE_F00D);
        read_check("wr63", 32'd63, 32'hCAFE_F00D);

        write_word(32'd5, 32'h1234_5678);
        read_check("wr5", 32'd5, 32'h1234_5678);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_rd5", Read_data, 32'h0);

        Mem_write  = 1'b1;
        write_data = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        Mem_write = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        read_check("blocked_in_reset", 32'd5, 32'h0);
        read_check("cleared2", 32'd2, 32'h0);
        read_check("cleared7", 32'd7, 32'h0);

        write_word(32'd5, 32'h0000_00A5);
        read_check("first_edge_write", 32'd5, 32'h0000_00A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
